// File: rtl/param_counter.sv
// Up/down counter with programmable step, wrap or saturate boundaries,
// enable prescaler, one-cycle boundary pulse and a sticky boundary flag.
module param_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     STEP_W   = 4,
  parameter bit              SATURATE = 1'b0,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              sel_in,
  input  logic              enable,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic              clr_flag,
  output logic [WIDTH-1:0]  out,
  output logic              ovf,
  output logic              ovf_sticky,
  output logic              zero
);

  // Extended width holds out+step and out+modulus without truncation.
  localparam int unsigned     EW       = WIDTH + STEP_W + 1;
  localparam int unsigned     PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [EW-1:0]   MAX_E    = EW'(MAX_VAL);
  localparam logic [EW-1:0]   MOD_E    = EW'(MAX_VAL + 64'd1);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;
  logic             tick;
  logic             boundary;
  logic             event_hit;
  logic [EW-1:0]    out_e;
  logic [EW-1:0]    step_e;
  logic [EW-1:0]    sum_e;
  logic [EW-1:0]    nxt_e;

  assign tick      = enable && (psc == PSC_LAST);
  assign event_hit = !sel_in && tick && boundary;
  assign zero      = (out == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    out_e    = EW'(out);
    step_e   = EW'(step);
    sum_e    = out_e + step_e;
    nxt_e    = out_e;
    boundary = 1'b0;
    if (!down) begin
      if (sum_e <= MAX_E) begin
        nxt_e = sum_e;
      end else begin
        boundary = 1'b1;
        nxt_e    = SATURATE ? MAX_E : (sum_e % MOD_E);
      end
    end else begin
      if (step_e <= out_e) begin
        nxt_e = out_e - step_e;
      end else begin
        boundary = 1'b1;
        nxt_e    = SATURATE ? '0 : ((out_e + MOD_E - (step_e % MOD_E)) % MOD_E);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out        <= '0;
      psc        <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (sel_in) begin
        out <= (in > MAX_W) ? MAX_W : in;
        psc <= '0;
      end else if (enable) begin
        psc <= tick ? '0 : psc + PSC_W'(1);
        if (tick) begin
          out <= nxt_e[WIDTH-1:0];
          ovf <= boundary;
        end
      end
      // A boundary event on the same edge as clr_flag wins.
      if (event_hit) begin
        ovf_sticky <= 1'b1;
      end else if (clr_flag) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: four parameterisations share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_v;
  logic       sel_in, enable, down, clr_flag;
  logic [3:0] step;

  logic [7:0] out0, out3;
  logic [3:0] out1, out2;
  logic [3:0] ovf_v, stk_v, zero_v;

  int checks   = 0;
  int failures = 0;

  // Configurations: 0 default, 1 mod-10 wrap, 2 mod-10 saturate, 3 prescale 4.
  longint cfg_max[4] = '{255, 9, 9, 255};
  bit     cfg_sat[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  longint cfg_pre[4] = '{1, 1, 1, 4};
  longint cfg_w[4]   = '{8, 4, 4, 8};

  longint m_out[4];
  longint m_psc[4];
  bit     m_ovf[4];
  bit     m_stk[4];

  always #5 clk = ~clk;

  param_counter u0 (
    .clk(clk), .reset(reset), .in(in_v), .sel_in(sel_in), .enable(enable),
    .down(down), .step(step), .clr_flag(clr_flag), .out(out0),
    .ovf(ovf_v[0]), .ovf_sticky(stk_v[0]), .zero(zero_v[0])
  );

  param_counter #(.WIDTH(4), .MAX_VAL(9)) u1 (
    .clk(clk), .reset(reset), .in(in_v[3:0]), .sel_in(sel_in), .enable(enable),
    .down(down), .step(step), .clr_flag(clr_flag), .out(out1),
    .ovf(ovf_v[1]), .ovf_sticky(stk_v[1]), .zero(zero_v[1])
  );

  param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u2 (
    .clk(clk), .reset(reset), .in(in_v[3:0]), .sel_in(sel_in), .enable(enable),
    .down(down), .step(step), .clr_flag(clr_flag), .out(out2),
    .ovf(ovf_v[2]), .ovf_sticky(stk_v[2]), .zero(zero_v[2])
  );

  param_counter #(.PRESCALE(4)) u3 (
    .clk(clk), .reset(reset), .in(in_v), .sel_in(sel_in), .enable(enable),
    .down(down), .step(step), .clr_flag(clr_flag), .out(out3),
    .ovf(ovf_v[3]), .ovf_sticky(stk_v[3]), .zero(zero_v[3])
  );

  function automatic logic [63:0] obs_out(input int i);
    case (i)
      0:       return 64'(out0);
      1:       return 64'(out1);
      2:       return 64'(out2);
      default: return 64'(out3);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_out[i] = 0;
      m_psc[i] = 0;
      m_ovf[i] = 1'b0;
      m_stk[i] = 1'b0;
    end
  endtask

  // Reference behaviour for one rising edge, from the counting rules.
  task automatic model_edge();
    longint modv, v, s, st;
    bit     ev;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      modv = cfg_max[i] + 1;
      st   = longint'(step);
      ev   = 1'b0;
      if (sel_in) begin
        v        = longint'(in_v) % (64'sd1 << cfg_w[i]);
        m_out[i] = (v > cfg_max[i]) ? cfg_max[i] : v;
        m_psc[i] = 0;
      end else if (enable) begin
        m_psc[i] = m_psc[i] + 1;
        if (m_psc[i] == cfg_pre[i]) begin
          m_psc[i] = 0;
          if (!down) begin
            s = m_out[i] + st;
            if (s > cfg_max[i]) begin
              ev = 1'b1;
              s  = cfg_sat[i] ? cfg_max[i] : s % modv;
            end
          end else begin
            s = m_out[i] - st;
            if (s < 0) begin
              ev = 1'b1;
              s  = cfg_sat[i] ? 0 : ((s % modv) + modv) % modv;
            end
          end
          m_out[i] = s;
        end
      end
      m_ovf[i] = ev;
      if (ev) m_stk[i] = 1'b1;
      else if (clr_flag) m_stk[i] = 1'b0;
    end
  endtask

  task automatic check_all(input string phase);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s.u%0d.out", phase, i),  obs_out(i),      64'(m_out[i]));
      check($sformatf("%s.u%0d.ovf", phase, i),  64'(ovf_v[i]),   64'(m_ovf[i]));
      check($sformatf("%s.u%0d.stk", phase, i),  64'(stk_v[i]),   64'(m_stk[i]));
      check($sformatf("%s.u%0d.zero", phase, i), 64'(zero_v[i]),  64'(m_out[i] == 0));
    end
  endtask

  task automatic step_cycle(input string phase);
    @(posedge clk);
    model_edge();
    #1;
    check_all(phase);
  endtask

  initial begin
    reset = 1'b1; in_v = '0; sel_in = 1'b0; enable = 1'b0;
    down = 1'b0; step = '0; clr_flag = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    step_cycle("reset_edge");
    reset = 1'b0;

    // Default config counts 1..255 then wraps to 0 with a single pulse.
    enable = 1'b1; step = 4'd1;
    for (int k = 1; k <= 256; k++) begin
      step_cycle("run");
      check("r031.out", 64'(out0), 64'(k % 256));
      check("r031.ovf", 64'(ovf_v[0]), (k == 256) ? 64'd1 : 64'd0);
    end
    step_cycle("run");
    check("r031.sticky", 64'(stk_v[0]), 64'd1);

    // Mod-10 wrap: 8 + 3 -> 1, then 1 - 4 -> 7.
    sel_in = 1'b1; in_v = 8'd8; enable = 1'b0;
    step_cycle("load8");
    sel_in = 1'b0; enable = 1'b1; down = 1'b0; step = 4'd3;
    step_cycle("wrap_up");
    check("r032.up.out", 64'(out1), 64'd1);
    check("r032.up.ovf", 64'(ovf_v[1]), 64'd1);
    down = 1'b1; step = 4'd4;
    step_cycle("wrap_dn");
    check("r032.dn.out", 64'(out1), 64'd7);
    check("r032.dn.ovf", 64'(ovf_v[1]), 64'd1);

    // Saturate: 2 - 5 clamps to 0, stays clamped, load 15 clamps to 9.
    sel_in = 1'b1; in_v = 8'd2; enable = 1'b0;
    step_cycle("load2");
    sel_in = 1'b0; enable = 1'b1; down = 1'b1; step = 4'd5;
    step_cycle("sat1");
    check("r033.a.out", 64'(out2), 64'd0);
    check("r033.a.ovf", 64'(ovf_v[2]), 64'd1);
    step_cycle("sat2");
    check("r033.b.out", 64'(out2), 64'd0);
    check("r033.b.ovf", 64'(ovf_v[2]), 64'd1);
    sel_in = 1'b1; in_v = 8'd15;
    step_cycle("load15");
    check("r033.load", 64'(out2), 64'd9);

    // Prescale 4: period of 4, stretched by 2 idle cycles, restarted by a load.
    sel_in = 1'b1; in_v = 8'd0; enable = 1'b0;
    step_cycle("psc_load");
    sel_in = 1'b0; enable = 1'b1; down = 1'b0; step = 4'd1;
    for (int k = 1; k <= 4; k++) begin
      step_cycle("psc_a");
      check("r034.a", 64'(out3), (k == 4) ? 64'd1 : 64'd0);
    end
    step_cycle("psc_b"); step_cycle("psc_b");
    enable = 1'b0;
    step_cycle("psc_idle"); step_cycle("psc_idle");
    check("r034.hold", 64'(out3), 64'd1);
    enable = 1'b1;
    step_cycle("psc_c");
    check("r034.c1", 64'(out3), 64'd1);
    step_cycle("psc_c");
    check("r034.c2", 64'(out3), 64'd2);
    step_cycle("psc_d"); step_cycle("psc_d");
    sel_in = 1'b1; in_v = 8'd10;
    step_cycle("psc_reload");
    sel_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step_cycle("psc_e");
      check("r034.e", 64'(out3), (k == 4) ? 64'd11 : 64'd10);
    end

    // Sticky flag: load with clr clears it, event with clr keeps it, clr alone clears.
    sel_in = 1'b1; in_v = 8'd9; enable = 1'b0; clr_flag = 1'b1;
    step_cycle("stk_load");
    check("r035.cleared", 64'(stk_v[1]), 64'd0);
    sel_in = 1'b0; enable = 1'b1; down = 1'b0; step = 4'd1;
    step_cycle("stk_ev");
    check("r035.ev_clr", 64'(stk_v[1]), 64'd1);
    enable = 1'b0;
    step_cycle("stk_clr");
    check("r035.clr", 64'(stk_v[1]), 64'd0);
    clr_flag = 1'b0;

    // Async reset between edges, with load and enable held during reset.
    enable = 1'b1; step = 4'd1;
    step_cycle("pre_rst"); step_cycle("pre_rst"); step_cycle("pre_rst");
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("r036.out", 64'(out0), 64'd0);
    check("r036.zero", 64'(zero_v[0]), 64'd1);
    check_all("async_rst");
    sel_in = 1'b1; in_v = 8'd77;
    step_cycle("rst_hold");
    check("r036.hold", 64'(out0), 64'd0);
    reset = 1'b0;
    step_cycle("rst_rel");
    check("r036.load", 64'(out3), 64'd77);
    sel_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step_cycle("rst_psc");
      check("r036.psc", 64'(out3), (k == 4) ? 64'd78 : 64'd77);
    end

    // Randomised traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 2000; n++) begin
      enable   = ($urandom % 4) != 0;
      sel_in   = ($urandom % 16) == 0;
      down     = $urandom % 2;
      step     = 4'($urandom % 16);
      clr_flag = ($urandom % 8) == 0;
      in_v     = 8'($urandom % 256);
      step_cycle("rand");
      if (($urandom % 64) == 0) begin
        #1 reset = 1'b1;
        model_reset();
        #1;
        check_all("rand_rst");
        reset = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
